// File: rtl/pwm_decoder.sv
// PWM duty decoder: measures rise-to-rise period and high time of an
// asynchronous PWM line and reports the quantized duty or a period error.
module pwm_decoder #(
    parameter int BITS        = 4,
    parameter int TIMER_DELAY = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pwm_in,
    output logic [BITS:0] duty_out,
    output logic          duty_valid,
    output logic          period_err
);

    localparam int FULL = 2 ** BITS;
    localparam int P    = FULL * TIMER_DELAY;
    localparam int TMO  = P + TIMER_DELAY;
    localparam int TOL  = TIMER_DELAY / 2;
    localparam int CW   = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        UNSYNC,
        HIGH,
        LOW
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          prev;
    logic [CW-1:0] period_cnt;
    logic [CW-1:0] high_cnt;

    logic          rise;
    logic          fall;
    logic          timeout;
    logic          in_tol;
    logic [CW:0]   period_len;
    logic [CW:0]   hsum;
    logic [CW:0]   quot;
    logic [BITS:0] duty_calc;

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    // Counter holds T-1 on the closing rise, so add one for the true length.
    assign period_len = {1'b0, period_cnt} + (CW + 1)'(1);
    assign timeout    = (period_cnt == CW'(TMO - 1));
    assign in_tol     = (period_len >= (CW + 1)'(P - TOL)) &&
                        (period_len <= (CW + 1)'(P + TOL));

    assign hsum      = {1'b0, high_cnt} + (CW + 1)'(TOL);
    assign quot      = hsum / (CW + 1)'(TIMER_DELAY);
    assign duty_calc = (quot > (CW + 1)'(FULL)) ? (BITS + 1)'(FULL)
                                                : quot[BITS:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= UNSYNC;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
        end else begin
            sync1      <= pwm_in;
            sync2      <= sync1;
            prev       <= sync2;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            if (rise) begin
                if (state != UNSYNC) begin
                    if (in_tol) begin
                        duty_out   <= duty_calc;
                        duty_valid <= 1'b1;
                    end else begin
                        period_err <= 1'b1;
                    end
                end
                state      <= HIGH;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else if (timeout) begin
                // Static line: report it as fully on or fully off.
                duty_out   <= sync2 ? (BITS + 1)'(FULL) : '0;
                duty_valid <= 1'b1;
                period_cnt <= '0;
                high_cnt   <= '0;
                state      <= UNSYNC;
            end else begin
                period_cnt <= period_cnt + CW'(1);
                case (state)
                    HIGH: begin
                        high_cnt <= high_cnt + CW'(1);
                        if (fall) state <= LOW;
                    end
                    UNSYNC, LOW: ;
                    default: state <= UNSYNC;
                endcase
            end
        end
    end

endmodule
